// File: rtl/ctrl_pkg.sv
// ctrl_pkg: shared definitions for the multi-cycle MIPS main control unit.
//   - opcode constants, ALUOp / PCSource / ALUSrcB encodings
//   - FSM state enum and the packed control-word struct
//   - opcode classification helpers
// Optional feature macro: CTRL_JUMP_EN (J opcode becomes a legal instruction).
package ctrl_pkg;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_LWC1  = 6'b110001;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;
  localparam logic [5:0] OP_J     = 6'b000010;

  // Base 3-bit ALUOp codes; zero-extended to ALUOP_W at the ports.
  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_RTYPE = 3'b010;
  localparam logic [2:0] ALU_AND   = 3'b011;
  localparam logic [2:0] ALU_SLT   = 3'b100;
  localparam logic [2:0] ALU_OR    = 3'b101;

  localparam logic [1:0] PCS_ALU    = 2'b00;
  localparam logic [1:0] PCS_ALUOUT = 2'b01;
  localparam logic [1:0] PCS_JUMP   = 2'b10;

  localparam logic [1:0] ASB_REG    = 2'b00;
  localparam logic [1:0] ASB_FOUR   = 2'b01;
  localparam logic [1:0] ASB_IMM    = 2'b10;
  localparam logic [1:0] ASB_IMM_SH = 2'b11;

  typedef enum logic [3:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEM_ADDR, S_MEM_RD, S_MEM_WB, S_MEM_WR,
    S_R_EXEC, S_R_WB, S_I_EXEC, S_I_WB, S_BRANCH, S_JUMP
  } state_t;

  typedef struct packed {
    logic       pc_write;
    logic       pc_write_cond;
    logic       branch_ne;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       memto_reg;
    logic       ir_write;
    logic       alu_src_a;
    logic       reg_write;
    logic       reg_dst;
    logic [1:0] pc_source;
    logic [1:0] alu_src_b;
  } ctrl_t;

  function automatic logic is_load(input logic [5:0] op);
    return (op == OP_LW) || (op == OP_LWC1);
  endfunction

  // ALU function shared by I_EXEC and I_WB for immediate arithmetic.
  function automatic logic [2:0] imm_aluop(input logic [5:0] op);
    case (op)
      OP_SLTI: return ALU_SLT;
      OP_ANDI: return ALU_AND;
      OP_ORI:  return ALU_OR;
      default: return ALU_ADD;
    endcase
  endfunction

  function automatic logic op_legal(input logic [5:0] op);
    case (op)
      OP_RTYPE, OP_LW, OP_LWC1, OP_SW, OP_BEQ, OP_BNE,
      OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: return 1'b1;
`ifdef CTRL_JUMP_EN
      OP_J:    return 1'b1;
`endif
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_out_decode.sv
// ctrl_out_decode: combinational Moore decode of the control word.
//   i_state     current FSM state
//   i_opcode    opcode to decode with (live in DECODE, latched afterwards)
//   i_mem_ready memory handshake, gates the FETCH write strobes only
//   o_ctrl      datapath control word, o_aluop ALU operation (zero-extended)
//   o_illegal   unsupported opcode seen in DECODE, o_busy not IDLE
// Optional feature macro: CTRL_JUMP_EN (enables the JUMP state outputs).
module ctrl_out_decode
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3
) (
  input  state_t               i_state,
  input  logic [5:0]           i_opcode,
  input  logic                 i_mem_ready,
  output ctrl_t                o_ctrl,
  output logic [ALUOP_W-1:0]   o_aluop,
  output logic                 o_illegal,
  output logic                 o_busy
);

  logic [2:0] w_aluop;

  always_comb begin
    o_ctrl    = '0;
    w_aluop   = ALU_ADD;
    o_illegal = 1'b0;
    o_busy    = (i_state != S_IDLE);
    case (i_state)
      S_FETCH: begin
        o_ctrl.mem_read  = 1'b1;
        o_ctrl.alu_src_b = ASB_FOUR;
        // PC and IR update only on the cycle the instruction word arrives
        o_ctrl.ir_write  = i_mem_ready;
        o_ctrl.pc_write  = i_mem_ready;
      end
      S_DECODE: begin
        o_ctrl.alu_src_b = ASB_IMM_SH;
        o_illegal        = !op_legal(i_opcode);
      end
      S_MEM_ADDR: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ASB_IMM;
      end
      S_MEM_RD: begin
        o_ctrl.mem_read = 1'b1;
        o_ctrl.iord     = 1'b1;
      end
      S_MEM_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.memto_reg = 1'b1;
      end
      S_MEM_WR: begin
        o_ctrl.mem_write = 1'b1;
        o_ctrl.iord      = 1'b1;
      end
      S_R_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ASB_REG;
        w_aluop          = ALU_RTYPE;
      end
      S_R_WB: begin
        o_ctrl.reg_write = 1'b1;
        o_ctrl.reg_dst   = 1'b1;
      end
      S_I_EXEC: begin
        o_ctrl.alu_src_a = 1'b1;
        o_ctrl.alu_src_b = ASB_IMM;
        w_aluop          = imm_aluop(i_opcode);
      end
      S_I_WB: begin
        o_ctrl.reg_write = 1'b1;
        w_aluop          = imm_aluop(i_opcode);
      end
      S_BRANCH: begin
        o_ctrl.alu_src_a     = 1'b1;
        o_ctrl.alu_src_b     = ASB_REG;
        w_aluop              = ALU_SUB;
        o_ctrl.pc_write_cond = 1'b1;
        o_ctrl.pc_source     = PCS_ALUOUT;
        o_ctrl.branch_ne     = (i_opcode == OP_BNE);
      end
`ifdef CTRL_JUMP_EN
      S_JUMP: begin
        o_ctrl.pc_write  = 1'b1;
        o_ctrl.pc_source = PCS_JUMP;
      end
`endif
      default: ;
    endcase
    o_aluop = ALUOP_W'(w_aluop);
  end

endmodule

// File: rtl/control_multiciclo.sv
// control_multiciclo: multi-cycle main control FSM for the 32-bit MIPS datapath.
// Ports:
//   clk, rst_n (async, active-low)
//   opcode    instruction [31:26], valid from DECODE onward
//   zero      ALU zero flag (consumed by datapath branch logic)
//   mem_ready memory access completes this cycle
//   PCWrite..RegDst, PCSource, ALUSrcB, ALUOp  datapath controls
//   illegal_op one-cycle pulse in DECODE for unsupported opcodes
//   busy      high in every state except IDLE
// Optional feature macro: CTRL_JUMP_EN (opcode 000010 dispatches to JUMP;
// otherwise it raises illegal_op).
module control_multiciclo
  import ctrl_pkg::*;
#(
  parameter int ALUOP_W = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [5:0]         opcode,
  input  logic               zero,
  input  logic               mem_ready,
  output logic               PCWrite,
  output logic               PCWriteCond,
  output logic               BranchNe,
  output logic               IorD,
  output logic               MemRead,
  output logic               MemWrite,
  output logic               MemtoReg,
  output logic               IRWrite,
  output logic               ALUSrcA,
  output logic               RegWrite,
  output logic               RegDst,
  output logic [1:0]         PCSource,
  output logic [1:0]         ALUSrcB,
  output logic [ALUOP_W-1:0] ALUOp,
  output logic               illegal_op,
  output logic               busy
);

  state_t     r_state;
  logic [5:0] r_opcode;
  logic [5:0] w_op;
  ctrl_t      w_ctrl;
  logic       w_unused;

  // zero is evaluated by the datapath through PCWriteCond/BranchNe
  assign w_unused = zero;

  // Opcode register is only loaded at the end of DECODE, so DECODE itself
  // must look at the live instruction-register bits.
  assign w_op = (r_state == S_DECODE) ? opcode : r_opcode;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state  <= S_IDLE;
      r_opcode <= '0;
    end else begin
      case (r_state)
        S_IDLE:   r_state <= S_FETCH;
        S_FETCH:  if (mem_ready) r_state <= S_DECODE;
        S_DECODE: begin
          r_opcode <= opcode;
          case (opcode)
            OP_RTYPE:                         r_state <= S_R_EXEC;
            OP_LW, OP_LWC1, OP_SW:            r_state <= S_MEM_ADDR;
            OP_BEQ, OP_BNE:                   r_state <= S_BRANCH;
            OP_ADDI, OP_SLTI, OP_ANDI, OP_ORI: r_state <= S_I_EXEC;
`ifdef CTRL_JUMP_EN
            OP_J:                             r_state <= S_JUMP;
`endif
            default:                          r_state <= S_FETCH;
          endcase
        end
        S_MEM_ADDR: r_state <= is_load(r_opcode) ? S_MEM_RD : S_MEM_WR;
        S_MEM_RD:   if (mem_ready) r_state <= S_MEM_WB;
        S_MEM_WR:   if (mem_ready) r_state <= S_FETCH;
        S_R_EXEC:   r_state <= S_R_WB;
        S_I_EXEC:   r_state <= S_I_WB;
        default:    r_state <= S_FETCH; // MEM_WB, R_WB, I_WB, BRANCH, JUMP
      endcase
    end
  end

  ctrl_out_decode #(.ALUOP_W(ALUOP_W)) u_dec (
    .i_state     (r_state),
    .i_opcode    (w_op),
    .i_mem_ready (mem_ready),
    .o_ctrl      (w_ctrl),
    .o_aluop     (ALUOp),
    .o_illegal   (illegal_op),
    .o_busy      (busy)
  );

  assign PCWrite     = w_ctrl.pc_write;
  assign PCWriteCond = w_ctrl.pc_write_cond;
  assign BranchNe    = w_ctrl.branch_ne;
  assign IorD        = w_ctrl.iord;
  assign MemRead     = w_ctrl.mem_read;
  assign MemWrite    = w_ctrl.mem_write;
  assign MemtoReg    = w_ctrl.memto_reg;
  assign IRWrite     = w_ctrl.ir_write;
  assign ALUSrcA     = w_ctrl.alu_src_a;
  assign RegWrite    = w_ctrl.reg_write;
  assign RegDst      = w_ctrl.reg_dst;
  assign PCSource    = w_ctrl.pc_source;
  assign ALUSrcB     = w_ctrl.alu_src_b;

endmodule

// File: tb/tb_control_multiciclo.sv
// Bench for control_multiciclo: a per-instruction reference model expands each
// instruction (opcode + memory stall counts) into the expected cycle-by-cycle
// control words, which are then replayed against the DUT.
// Honors CTRL_JUMP_EN the same way as the design.
module tb_control_multiciclo;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [5:0] opcode = 6'd0;
  logic       zero = 1'b0;
  logic       mem_ready = 1'b0;
  logic       PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite;
  logic       MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst;
  logic [1:0] PCSource, ALUSrcB;
  logic [2:0] ALUOp;
  logic       illegal_op, busy;

  control_multiciclo #(.ALUOP_W(3)) dut (
    .clk(clk), .rst_n(rst_n), .opcode(opcode), .zero(zero), .mem_ready(mem_ready),
    .PCWrite(PCWrite), .PCWriteCond(PCWriteCond), .BranchNe(BranchNe), .IorD(IorD),
    .MemRead(MemRead), .MemWrite(MemWrite), .MemtoReg(MemtoReg), .IRWrite(IRWrite),
    .ALUSrcA(ALUSrcA), .RegWrite(RegWrite), .RegDst(RegDst), .PCSource(PCSource),
    .ALUSrcB(ALUSrcB), .ALUOp(ALUOp), .illegal_op(illegal_op), .busy(busy)
  );

  always #5 clk = ~clk;

  // Observed control word, bit layout shared with the masks below
  logic [19:0] obs;
  assign obs = {PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg,
                IRWrite, ALUSrcA, RegWrite, RegDst, PCSource, ALUSrcB, ALUOp,
                illegal_op, busy};

  localparam logic [19:0] PCW = 20'h80000, PCC = 20'h40000, BNE = 20'h20000,
                          IOD = 20'h10000, MRD = 20'h08000, MWR = 20'h04000,
                          M2R = 20'h02000, IRW = 20'h01000, ASA = 20'h00800,
                          RWR = 20'h00400, RDS = 20'h00200, ILL = 20'h00002,
                          BSY = 20'h00001;

  function automatic logic [19:0] pcs(input int x); return 20'(x) << 7; endfunction
  function automatic logic [19:0] asb(input int x); return 20'(x) << 5; endfunction
  function automatic logic [19:0] aop(input int x); return 20'(x) << 2; endfunction

  typedef struct { logic mr; logic [5:0] op; logic [19:0] v; } cyc_t;
  cyc_t q[$];

  int total = 0;
  int bad   = 0;

  function automatic logic rb(); return 1'($urandom); endfunction
  function automatic logic [5:0] r6(); return 6'($urandom); endfunction

  // Instruction classes from the ISA table
  localparam int K_R = 0, K_LD = 1, K_SW = 2, K_BR = 3, K_I = 4, K_J = 5, K_ILL = 6;

  function automatic int cls(input logic [5:0] op);
    case (op)
      6'b000000: return K_R;
      6'b100011, 6'b110001: return K_LD;
      6'b101011: return K_SW;
      6'b000100, 6'b000101: return K_BR;
      6'b001000, 6'b001010, 6'b001100, 6'b001101: return K_I;
`ifdef CTRL_JUMP_EN
      6'b000010: return K_J;
`endif
      default: return K_ILL;
    endcase
  endfunction

  function automatic int imm_op(input logic [5:0] op);
    case (op)
      6'b001010: return 4; // slt
      6'b001100: return 3; // and
      6'b001101: return 5; // or
      default:   return 0; // add
    endcase
  endfunction

  task automatic push(input logic mr, input logic [5:0] op, input logic [19:0] v);
    cyc_t c;
    c.mr = mr; c.op = op; c.v = v;
    q.push_back(c);
  endtask

  // Expand one instruction into expected cycles. sf / sm are the number of
  // not-ready cycles in the fetch and the data-memory access respectively.
  // Opcode is garbage outside DECODE, so later states must use a latched copy.
  task automatic build(input logic [5:0] op, input int sf, input int sm);
    int k;
    k = cls(op);
    repeat (sf) push(1'b0, r6(), MRD | asb(1) | BSY);
    push(1'b1, r6(), MRD | asb(1) | IRW | PCW | BSY);
    push(rb(), op, asb(3) | BSY | ((k == K_ILL) ? ILL : 20'h0));
    case (k)
      K_R: begin
        push(rb(), r6(), ASA | asb(0) | aop(2) | BSY);
        push(rb(), r6(), RWR | RDS | BSY);
      end
      K_LD: begin
        push(rb(), r6(), ASA | asb(2) | BSY);
        repeat (sm) push(1'b0, r6(), MRD | IOD | BSY);
        push(1'b1, r6(), MRD | IOD | BSY);
        push(rb(), r6(), RWR | M2R | BSY);
      end
      K_SW: begin
        push(rb(), r6(), ASA | asb(2) | BSY);
        repeat (sm) push(1'b0, r6(), MWR | IOD | BSY);
        push(1'b1, r6(), MWR | IOD | BSY);
      end
      K_I: begin
        push(rb(), r6(), ASA | asb(2) | aop(imm_op(op)) | BSY);
        push(rb(), r6(), RWR | aop(imm_op(op)) | BSY);
      end
      K_BR: push(rb(), r6(), ASA | aop(1) | PCC | pcs(1) | BSY |
                             ((op == 6'b000101) ? BNE : 20'h0));
      K_J:  push(rb(), r6(), PCW | pcs(2) | BSY);
      default: ;
    endcase
  endtask

  task automatic check(input string tag, input logic [19:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Replay n queued cycles (n<0: all). Inputs change just after the edge,
  // outputs are sampled on the falling edge.
  task automatic run(input string tag, input int n);
    cyc_t c;
    int i;
    i = 0;
    while (q.size() > 0 && (n < 0 || i < n)) begin
      c = q.pop_front();
      @(posedge clk);
      #1;
      opcode = c.op; mem_ready = c.mr; zero = rb();
      @(negedge clk);
      check(tag, c.v);
      i++;
    end
  endtask

  initial begin
    // Reset state
    repeat (2) @(negedge clk);
    check("reset", 20'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("idle", 20'h0);

    // R-type, no stalls: 4 cycles
    build(6'b000000, 0, 0); run("rtype", -1);
    // LW with 3 stalled MEM_RD cycles: 8 cycles
    build(6'b100011, 0, 3); run("lw_stall", -1);
    // BNE and BEQ
    build(6'b000101, 0, 0); run("bne", -1);
    build(6'b000100, 1, 0); run("beq", -1);
    // Illegal opcode: 2 cycles, single illegal_op pulse
    build(6'b111111, 0, 0); run("illegal", -1);
    // J: JUMP when enabled, illegal otherwise
    build(6'b000010, 0, 0); run("jump", -1);
    // SW with stalls, LWC1, each immediate op
    build(6'b101011, 2, 2); run("sw", -1);
    build(6'b110001, 0, 1); run("lwc1", -1);
    build(6'b001000, 0, 0); build(6'b001010, 0, 0);
    build(6'b001100, 0, 0); build(6'b001101, 0, 0);
    run("itype", -1);

    // Reset in the middle of a stalled MEM_RD
    build(6'b100011, 0, 6);
    run("pre_rst", 5);
    q.delete();
    #($urandom_range(0, 2)) rst_n = 1'b0;
    #1 check("rst_async", 20'h0);
    @(negedge clk);
    check("rst_hold", 20'h0);
    @(posedge clk); #1 rst_n = 1'b1;
    @(negedge clk);
    check("rst_idle", 20'h0);
    build(6'b000000, 0, 0); run("post_rst", -1);

    // Randomized instruction stream
    for (int n = 0; n < 150; n++) begin
      logic [5:0] op;
      if (rb()) begin
        case ($urandom_range(0, 11))
          0: op = 6'b000000; 1: op = 6'b100011; 2: op = 6'b110001;
          3: op = 6'b101011; 4: op = 6'b000100; 5: op = 6'b000101;
          6: op = 6'b001000; 7: op = 6'b001010; 8: op = 6'b001100;
          9: op = 6'b001101; 10: op = 6'b000010; default: op = 6'b111111;
        endcase
      end else begin
        op = r6();
      end
      build(op, $urandom_range(0, 3), $urandom_range(0, 3));
      run("random", -1);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/control_multiciclo.md
# control_multiciclo

Multi-cycle main control unit for the 32-bit MIPS datapath, replacing the single-cycle opcode decoder. It sequences each instruction through fetch, decode, execute, memory and write-back states. It drives the shared-ALU/shared-memory datapath controls and stalls on a memory ready handshake. ALU operation width is parametrised, and it adds BNE, illegal-opcode detection and optional J support.

## Interface
- ALUOP_W, 3, width of ALUOp; must be ≥3; encodings are zero-extended
- clk  in  1  system clock, rising edge
- rst_n  in  1  reset, asynchronous and active-low
- opcode  in  6  instruction bits [31:26] from the instruction register; valid from DECODE onward
- zero  in  1  ALU zero flag; used only in BRANCH
- mem_ready  in  1  memory access completes this cycle
- PCWrite, PCWriteCond, BranchNe, IorD, MemRead, MemWrite, MemtoReg, IRWrite, ALUSrcA, RegWrite, RegDst  out  1 each  datapath controls
- PCSource  out  2  00 ALU result, 01 ALUOut (branch target), 10 jump target
- ALUSrcB  out  2  00 reg B, 01 constant 4, 10 sign-ext imm, 11 sign-ext imm<<2
- ALUOp  out  ALUOP_W  000 add, 001 sub, 010 R-type (funct), 011 and, 100 slt, 101 or
- illegal_op  out  1  one-cycle pulse in DECODE for an unsupported opcode
- busy  out  1  high in every state except IDLE

## Operation
- States: IDLE, FETCH, DECODE, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, R_EXEC, R_WB, I_EXEC, I_WB, BRANCH, JUMP.
- Outputs are decoded from the state register (Moore), except where gated by mem_ready. Any output not listed for a state is 0.
- IDLE: all outputs 0. Next state is FETCH.
- FETCH: MemRead=1, IorD=0, ALUSrcA=0, ALUSrcB=01, ALUOp=add. IRWrite=1 and PCWrite=1 only when mem_ready=1. State holds while mem_ready=0. On mem_ready the next state is DECODE.
- DECODE: ALUSrcA=0, ALUSrcB=11, ALUOp=add (branch target into ALUOut). Opcode dispatch:
  - 000000 → R_EXEC
  - 100011 (LW), 110001 (LWC1), 101011 (SW) → MEM_ADDR
  - 000100 (BEQ), 000101 (BNE) → BRANCH
  - 001000 (ADDI), 001010 (SLTI), 001100 (ANDI), 001101 (ORI) → I_EXEC
  - 000010 (J) → JUMP, only when CTRL_JUMP_EN is defined
  - any other opcode: illegal_op=1, next state FETCH
- MEM_ADDR: ALUSrcA=1, ALUSrcB=10, ALUOp=add. Next state is MEM_RD for loads and MEM_WR for SW.
- MEM_RD: MemRead=1, IorD=1. State holds until mem_ready, then MEM_WB.
- MEM_WB: RegWrite=1, MemtoReg=1, RegDst=0. Next state FETCH.
- MEM_WR: MemWrite=1, IorD=1. State holds until mem_ready, then FETCH.
- R_EXEC: ALUSrcA=1, ALUSrcB=00, ALUOp=010, then R_WB. R_WB: RegWrite=1, RegDst=1, MemtoReg=0, then FETCH.
- I_EXEC: ALUSrcA=1, ALUSrcB=10. ALUOp is add for ADDI, slt for SLTI, and for ANDI, or for ORI. Next state I_WB.
- I_WB: RegWrite=1, RegDst=0. ALUOp holds the I_EXEC value. Next state FETCH.
- BRANCH: ALUSrcA=1, ALUSrcB=00, ALUOp=sub, PCWriteCond=1, PCSource=01. BranchNe=1 for BNE; the datapath then takes the branch when zero=0. Next state FETCH.
- JUMP: PCWrite=1, PCSource=10. Next state FETCH.
- Opcode is latched into an internal register in DECODE. Later states use the latched copy, not the live input.

## Timing
- Reset: asynchronous entry into IDLE. All outputs are 0 and busy=0 while rst_n is low, including a reset asserted mid-instruction. No write strobe may glitch high.
- First FETCH is one cycle after rst_n deasserts.
- Cycles per instruction with mem_ready tied high: R 4, LW 5, SW 4, I-type 4, BEQ/BNE 3, J 3, illegal 2.
- Each cycle with mem_ready=0 in FETCH, MEM_RD or MEM_WR adds one cycle. mem_ready is ignored in all other states.
- PCWrite and IRWrite assert in exactly one cycle per fetch.
- MemRead and MemWrite are never high in the same cycle.

## Configuration
- CTRL_JUMP_EN defined: opcode 000010 goes to JUMP.
- CTRL_JUMP_EN undefined: JUMP state and PCSource=10 are unreachable, and 000010 raises illegal_op.

## Structure
- Shared package ctrl_pkg holds:
  - opcode localparams
  - ALUOp encodings
  - PCSource and ALUSrcB encodings
  - state enum
- One sub-module, ctrl_out_decode: purely combinational mapping of (state, latched opcode, mem_ready) to outputs. Keeps the FSM register and next-state logic separate.

## Test plan
- Reset mid-MEM_RD (rst_n low for 1 cycle at a random phase) → outputs 0 at once; IDLE, then FETCH one cycle after release.
- R-type with mem_ready=1 → exactly 4 cycles: FETCH (IRWrite=1, PCWrite=1), DECODE, R_EXEC (ALUOp=010), R_WB (RegWrite=1, RegDst=1).
- LW with mem_ready low for 3 cycles in MEM_RD → 8 cycles total. MemRead=1, IorD=1 held throughout; MEM_WB has MemtoReg=1.
- BNE → BRANCH with PCWriteCond=1, BranchNe=1, ALUOp=001, PCSource=01. Next cycle is FETCH.
- Opcode 111111 → illegal_op high for exactly one cycle in DECODE; no RegWrite, MemWrite or PCWrite pulse; back in FETCH after 2 cycles.
- Opcode 000010 → PCWrite=1, PCSource=10 when CTRL_JUMP_EN is defined; illegal_op=1 when it is not.
